// File: rtl/demux16_serie_pkg.sv
// Shared definitions for the 16-way serial demultiplexer: FSM encoding and
// start/end write indices for both fill orders.
package demux16_serie_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURA  = 2'd1,
    COMPLETO = 2'd2
  } estado_t;

  localparam logic [3:0] INDICE_INICIO_LSB = 4'd0;
  localparam logic [3:0] INDICE_INICIO_MSB = 4'd15;

  function automatic logic [3:0] indice_inicio(input logic msb_primero);
    return msb_primero ? INDICE_INICIO_MSB : INDICE_INICIO_LSB;
  endfunction

  // The last index written in a sequential word is the opposite end of the start.
  function automatic logic [3:0] indice_final(input logic msb_primero);
    return msb_primero ? INDICE_INICIO_LSB : INDICE_INICIO_MSB;
  endfunction

endpackage

// File: rtl/demux16_indice.sv
// 4-bit wrapping index counter, counts up (LSB first) or down (MSB first).
// Load to start takes priority over step; result visible the cycle after.
module demux16_indice
  import demux16_serie_pkg::*;
#(
  parameter bit MSB_PRIMERO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       carga,
  input  logic       paso,
  output logic [3:0] cuenta
);

  localparam logic [3:0] INICIO = indice_inicio(MSB_PRIMERO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cuenta <= INICIO;
    end else if (carga) begin
      cuenta <= INICIO;
    end else if (paso) begin
      cuenta <= MSB_PRIMERO ? (cuenta - 4'd1) : (cuenta + 4'd1);
    end
  end

endmodule

// File: rtl/demux16_serie.sv
// Routes a serial bit into a 16-bit register, addressed or auto-indexed; one-cycle latency.
// Inputs are dropped during the COMPLETO cycle (Ocupado); Paridad only when DEMUX16_PARIDAD_EN.
module demux16_serie
  import demux16_serie_pkg::*;
#(
  parameter bit MSB_PRIMERO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Din,
  input  logic        Valido,
  input  logic [3:0]  Seleccion,
  input  logic        Modo,
  input  logic        Limpiar,
  output logic [15:0] Qn,
  output logic [3:0]  Indice,
  output logic        Listo,
  output logic        Ocupado,
  output logic        Paridad
);

  localparam logic [3:0] INDICE_FIN = indice_final(MSB_PRIMERO);

  estado_t     estado, estado_sig;
  logic        escribe, secuencial, ultimo;
  logic [3:0]  idx;
  logic [15:0] qn_sig;

  // Direct addressing only applies from IDLE; CAPTURA always follows the counter.
  assign escribe    = Valido && !Limpiar && (estado == IDLE || estado == CAPTURA);
  assign secuencial = escribe && (estado == CAPTURA || Modo);
  assign ultimo     = secuencial && (Indice == INDICE_FIN);
  assign idx        = (estado == IDLE && !Modo) ? Seleccion : Indice;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= IDLE;
    end else begin
      estado <= estado_sig;
    end
  end

  always_comb begin
    estado_sig = estado;
    if (Limpiar) begin
      estado_sig = IDLE;
    end else begin
      case (estado)
        IDLE:     if (secuencial) estado_sig = ultimo ? COMPLETO : CAPTURA;
        CAPTURA:  if (ultimo) estado_sig = COMPLETO;
        COMPLETO: estado_sig = IDLE;
        default:  estado_sig = IDLE;
      endcase
    end
  end

  always_comb begin
    Listo   = (estado == COMPLETO);
    Ocupado = (estado == COMPLETO);
  end

  always_comb begin
    qn_sig = Qn;
    if (Limpiar) begin
      qn_sig = '0;
    end else if (escribe) begin
      qn_sig[idx] = Din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Qn <= '0;
    end else begin
      Qn <= qn_sig;
    end
  end

  demux16_indice #(
    .MSB_PRIMERO(MSB_PRIMERO)
  ) u_indice (
    .clk   (clk),
    .rst_n (rst_n),
    .carga (Limpiar),
    .paso  (secuencial),
    .cuenta(Indice)
  );

`ifdef DEMUX16_PARIDAD_EN
  // Parity is taken from the next Qn so it lands in the same cycle as the word.
  logic paridad_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paridad_q <= 1'b0;
    end else begin
      paridad_q <= ^qn_sig;
    end
  end
  assign Paridad = paridad_q;
`else
  assign Paridad = 1'b0;
`endif

endmodule

// File: tb/tb_demux16_serie.sv
// Scoreboard bench for demux16_serie: one instance per fill order, directed vectors,
// expectations queued by the stimulus and checked by a negedge monitor.
module tb_demux16_serie;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        din[2], valido[2], modo[2], limpiar[2];
  logic [3:0]  sel[2];
  logic [15:0] qn[2];
  logic [3:0]  ind[2];
  logic        listo[2], ocup[2], par[2];

  demux16_serie #(.MSB_PRIMERO(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .Din(din[0]), .Valido(valido[0]), .Seleccion(sel[0]),
    .Modo(modo[0]), .Limpiar(limpiar[0]), .Qn(qn[0]), .Indice(ind[0]),
    .Listo(listo[0]), .Ocupado(ocup[0]), .Paridad(par[0])
  );

  demux16_serie #(.MSB_PRIMERO(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .Din(din[1]), .Valido(valido[1]), .Seleccion(sel[1]),
    .Modo(modo[1]), .Limpiar(limpiar[1]), .Qn(qn[1]), .Indice(ind[1]),
    .Listo(listo[1]), .Ocupado(ocup[1]), .Paridad(par[1])
  );

  typedef struct {
    int          tgt;
    int          d;
    string       nm;
    logic [15:0] qn;
    logic [3:0]  ind;
    logic        listo;
    logic        ocup;
    logic        par;
    int          lcnt;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   lcnt[2] = '{0, 0};
  int   exp_lc[2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) if (listo[d] === 1'b1) lcnt[d] = lcnt[d] + 1;
    while (sb.size() > 0 && sb[0].tgt <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_vec = n_vec + 1;
      if (qn[e.d] !== e.qn || ind[e.d] !== e.ind || listo[e.d] !== e.listo ||
          ocup[e.d] !== e.ocup || par[e.d] !== e.par || lcnt[e.d] != e.lcnt) begin
        n_err = n_err + 1;
        $display("FAIL %s dut%0d cyc%0d: got qn=%h ind=%0d listo=%b ocup=%b par=%b pulses=%0d, want qn=%h ind=%0d listo=%b ocup=%b par=%b pulses=%0d",
                 e.nm, e.d, cyc, qn[e.d], ind[e.d], listo[e.d], ocup[e.d], par[e.d], lcnt[e.d],
                 e.qn, e.ind, e.listo, e.ocup, e.par, e.lcnt);
      end
    end
  end

  function automatic logic par_of(input logic [15:0] q);
`ifdef DEMUX16_PARIDAD_EN
    return ^q;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] start_of(input int d);
    return (d == 1) ? 4'd15 : 4'd0;
  endfunction

  task automatic push_exp(input int d, input int dly, input string nm, input logic [15:0] q,
                          input logic [3:0] i, input logic l, input logic o);
    exp_t e;
    e.tgt = cyc + dly; e.d = d; e.nm = nm; e.qn = q; e.ind = i;
    e.listo = l; e.ocup = o; e.par = par_of(q); e.lcnt = exp_lc[d];
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic v, input logic m, input logic [3:0] s,
                       input logic b, input logic c);
    valido[d] = v; modo[d] = m; sel[d] = s; din[d] = b; limpiar[d] = c;
  endtask

  // Direct-mode table: {Seleccion, Din, Valido, Limpiar, expected Qn}
  logic [3:0]  t_sel[7] = '{4'd9, 4'd0, 4'd9, 4'd5, 4'd3, 4'd15, 4'd2};
  logic        t_din[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic        t_val[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic        t_clr[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [15:0] t_exp[7] = '{16'h0200, 16'h0201, 16'h0001, 16'h0001, 16'h0000, 16'h8000, 16'h0000};

  initial begin
    logic [15:0] w, w2, q, mk;
    int          m;

    w  = 16'hA5C3;
    w2 = 16'h1234;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    step(); step();
    for (int d = 0; d < 2; d++) push_exp(d, 0, "reset", 16'h0000, start_of(d), 1'b0, 1'b0);
    step();
    rst_n = 1'b1;

    for (int r = 0; r < 7; r++) begin
      for (int d = 0; d < 2; d++) begin
        drive(d, t_val[r], 1'b0, t_sel[r], t_din[r], t_clr[r]);
        push_exp(d, 1, $sformatf("direct_row%0d", r), t_exp[r], start_of(d), 1'b0, 1'b0);
      end
      step();
    end
    for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    // LSB-first contiguous stream on u0
    for (int i = 0; i < 16; i++) begin
      drive(0, 1'b1, 1'b1, 4'd0, w[i], 1'b0);
      m = (i == 15) ? 32'hFFFF : ((1 << (i + 1)) - 1);
      mk = m[15:0];
      if (i == 15) exp_lc[0] = exp_lc[0] + 1;
      push_exp(0, 1, $sformatf("lsb_bit%0d", i), w & mk, 4'((i + 1) & 15), i == 15, i == 15);
      step();
    end
    drive(0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    push_exp(0, 1, "lsb_after", w, 4'd0, 1'b0, 1'b0);
    step();

    // MSB-first stream on u1 with idle gaps
    for (int i = 0; i < 16; i++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        drive(1, 1'b0, 1'b1, 4'd0, $urandom_range(0, 1), 1'b0);
        step();
      end
      drive(1, 1'b1, 1'b1, 4'd0, w[15 - i], 1'b0);
      m = ~((1 << (15 - i)) - 1);
      mk = m[15:0];
      q = w & mk;
      if (i == 15) exp_lc[1] = exp_lc[1] + 1;
      push_exp(1, 1, $sformatf("msb_bit%0d", i), q, 4'((14 - i) & 15), i == 15, i == 15);
      step();
      if (i == 7) begin
        drive(1, 1'b0, 1'b0, 4'd3, ~w[7], 1'b0);
        push_exp(1, 1, "msb_gap_hold", q, 4'd7, 1'b0, 1'b0);
        step();
      end
    end
    drive(1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    push_exp(1, 1, "msb_after", w, 4'd15, 1'b0, 1'b0);
    step();

    // Second word over the first without clearing; Modo/Seleccion ignored in CAPTURA
    for (int i = 0; i < 16; i++) begin
      drive(0, 1'b1, (i == 0), 4'hF, w2[i], 1'b0);
      m = (i == 15) ? 32'hFFFF : ((1 << (i + 1)) - 1);
      mk = m[15:0];
      q = (16'hA5C3 & ~mk) | (w2 & mk);
      if (i == 15) exp_lc[0] = exp_lc[0] + 1;
      push_exp(0, 1, $sformatf("keep_bit%0d", i), q, 4'((i + 1) & 15), i == 15, i == 15);
      step();
    end
    drive(0, 1'b1, 1'b1, 4'd0, ~w2[0], 1'b0);
    push_exp(0, 1, "completo_drop", w2, 4'd0, 1'b0, 1'b0);
    step();
    drive(0, 1'b1, 1'b1, 4'd0, ~w2[0], 1'b0);
    push_exp(0, 1, "restart_idx0", 16'h1235, 4'd1, 1'b0, 1'b0);
    step();
    for (int j = 1; j < 7; j++) begin
      drive(0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0);
      if (j == 6) push_exp(0, 1, "seven_bits", 16'h127F, 4'd7, 1'b0, 1'b0);
      step();
    end
    drive(0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    step();

    // Asynchronous reset mid-capture, seen before the next edge
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) push_exp(d, 0, "reset_mid", 16'h0000, start_of(d), 1'b0, 1'b0);
    #1;
    if (qn[0] !== 16'h0000 || ind[0] !== 4'd0) begin
      n_err = n_err + 1;
      $display("FAIL reset_async dut0: got qn=%h ind=%0d, want qn=0000 ind=0", qn[0], ind[0]);
    end
    if (qn[1] !== 16'h0000 || ind[1] !== 4'd15) begin
      n_err = n_err + 1;
      $display("FAIL reset_async dut1: got qn=%h ind=%0d, want qn=0000 ind=15", qn[1], ind[1]);
    end
    n_vec = n_vec + 2;
    step();
    rst_n = 1'b1;

    // Limpiar with Valido mid-capture on u1
    for (int i = 0; i < 3; i++) begin
      drive(1, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0);
      if (i == 2) push_exp(1, 1, "msb_three", 16'hE000, 4'd12, 1'b0, 1'b0);
      step();
    end
    drive(1, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1);
    push_exp(1, 1, "clear_capture", 16'h0000, 4'd15, 1'b0, 1'b0);
    step();
    drive(1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    // Parity on odd and even weights
    for (int s = 0; s < 4; s++) begin
      drive(0, 1'b1, 1'b0, 4'(s), 1'b1, 1'b0);
      if (s == 2) push_exp(0, 1, "parity_0007", 16'h0007, 4'd0, 1'b0, 1'b0);
      if (s == 3) push_exp(0, 1, "parity_000F", 16'h000F, 4'd0, 1'b0, 1'b0);
      step();
      if (s == 2) begin
        n_vec = n_vec + 1;
        if (qn[0] !== 16'h0007 || par[0] !== par_of(16'h0007)) begin
          n_err = n_err + 1;
          $display("FAIL parity_direct dut0: got qn=%h par=%b, want qn=0007 par=%b",
                   qn[0], par[0], par_of(16'h0007));
        end
      end
    end
    drive(0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    repeat (3) step();

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec = n_vec + 1;
      n_err = n_err + 1;
      $display("FAIL %s dut%0d: never checked, due cyc%0d now cyc%0d", e.nm, e.d, e.tgt, cyc);
    end
    for (int d = 0; d < 2; d++) begin
      n_vec = n_vec + 1;
      if (lcnt[d] != exp_lc[d]) begin
        n_err = n_err + 1;
        $display("FAIL listo_total dut%0d: got %0d pulses, want %0d", d, lcnt[d], exp_lc[d]);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    if (n_err != 0) $display("TEST FAILED");
    else $display("TEST PASSED");
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit at cyc%0d, want completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
